// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the external interrupt controller: FSM states,
// default bus register map and the Cause-code helper.
package int_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_t;

  localparam logic [31:0] CAUSE_SYSCALL    = 32'd8;
  localparam logic [31:0] CAUSE_BASE_DEF   = 32'd16;
  localparam logic [31:0] VEC_ADDR_DEF     = 32'h0000_040C;
  localparam logic [31:0] EN_ADDR_DEF      = 32'hFFFF_FF00;
  localparam logic [31:0] CLR_ADDR_DEF     = 32'hFFFF_FF04;
  localparam logic [31:0] EOI_ADDR_DEF     = 32'hFFFF_FF08;
  localparam logic [1:0]  MEMWRITE_WORD    = 2'd1;

  function automatic logic [31:0] cause_code(input logic [31:0] base, input logic [3:0] idx);
    cause_code = base + {28'd0, idx};
  endfunction

endpackage

// File: rtl/int_ctrl_sync_edge.sv
// Two-flop synchroniser for one asynchronous IRQ line followed by a
// registered rising-edge pulse.
module int_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1    <= async_in;
      s2    <= s1;
      s3    <= s2;
      pulse <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// External interrupt controller: latches IRQ edges, picks the highest-priority
// enabled source and handshakes with the CPU by snooping its bus traffic.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int          N_IRQ      = 8,
  parameter logic [31:0] CAUSE_BASE = CAUSE_BASE_DEF,
  parameter logic [31:0] VEC_ADDR   = VEC_ADDR_DEF,
  parameter logic [31:0] EN_ADDR    = EN_ADDR_DEF,
  parameter logic [31:0] CLR_ADDR   = CLR_ADDR_DEF,
  parameter logic [31:0] EOI_ADDR   = EOI_ADDR_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq,
  input  logic             Memread,
  input  logic [1:0]       Memwrite,
  input  logic [31:0]      Addr,
  input  logic [31:0]      BUS,
  output logic             INTin,
  output logic [31:0]      INTnum
);

  function automatic logic [3:0] prio_sel(input logic [N_IRQ-1:0] v);
    prio_sel = 4'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (v[i]) prio_sel = i[3:0];
    end
  endfunction

  logic [N_IRQ-1:0] edges;
  logic [N_IRQ-1:0] pending, pending_nxt;
  logic [N_IRQ-1:0] enable, enable_nxt;
  logic [N_IRQ-1:0] active, sel_mask;
  logic [3:0]       sel, sel_held, sel_held_nxt;
  logic             valid, ack;
  logic             word_wr, en_wr, clr_wr, eoi_wr, vec_rd;
  logic             intin_nxt;
  logic [31:0]      intnum_nxt;
  state_t           state, state_nxt;
  logic             unused_bits;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
    int_sync_edge u_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (irq[g]),
      .pulse    (edges[g])
    );
  end

  assign word_wr  = (Memwrite == MEMWRITE_WORD);
  assign en_wr    = word_wr && (Addr == EN_ADDR);
  assign clr_wr   = word_wr && (Addr == CLR_ADDR);
  assign eoi_wr   = word_wr && (Addr == EOI_ADDR);
  assign vec_rd   = Memread && (Addr == VEC_ADDR);
  assign ack      = (state == REQ) && vec_rd;

  assign active   = pending & enable;
  assign valid    = |active;
  assign sel      = prio_sel(active);
  assign sel_mask = N_IRQ'(1) << sel_held;

  assign unused_bits = ^{BUS, CAUSE_SYSCALL};

  // New edges are OR-ed in last so a same-cycle set beats any clear.
  always_comb begin
    enable_nxt  = en_wr ? BUS[N_IRQ-1:0] : enable;
    pending_nxt = pending;
    if (clr_wr) pending_nxt = pending_nxt & ~BUS[N_IRQ-1:0];
    if (ack)    pending_nxt = pending_nxt & ~sel_mask;
    pending_nxt = pending_nxt | edges;
  end

  always_comb begin
    state_nxt    = state;
    intin_nxt    = INTin;
    intnum_nxt   = INTnum;
    sel_held_nxt = sel_held;
    case (state)
      IDLE: begin
        if (valid) begin
          state_nxt    = REQ;
          intin_nxt    = 1'b1;
          intnum_nxt   = cause_code(CAUSE_BASE, sel);
          sel_held_nxt = sel;
        end
      end
      REQ: begin
        if (ack) begin
          state_nxt = SVC;
          intin_nxt = 1'b0;
        end else if ((pending_nxt & enable_nxt & sel_mask) == '0) begin
          state_nxt = IDLE;
          intin_nxt = 1'b0;
        end
      end
      SVC: begin
        intin_nxt = 1'b0;
        if (eoi_wr) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        intin_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      INTin    <= 1'b0;
      INTnum   <= 32'd0;
      sel_held <= 4'd0;
      pending  <= '0;
      enable   <= '0;
    end else begin
      state    <= state_nxt;
      INTin    <= intin_nxt;
      INTnum   <= intnum_nxt;
      sel_held <= sel_held_nxt;
      pending  <= pending_nxt;
      enable   <= enable_nxt;
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed, table-driven bench for int_ctrl: one vector per clock, outputs
// compared 1 time unit after the rising edge.
module tb_int_ctrl;

  localparam int          N     = 8;
  localparam logic [31:0] A_VEC = 32'h0000_040C;
  localparam logic [31:0] A_EN  = 32'hFFFF_FF00;
  localparam logic [31:0] A_CLR = 32'hFFFF_FF04;
  localparam logic [31:0] A_EOI = 32'hFFFF_FF08;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq;
  logic          Memread;
  logic [1:0]    Memwrite;
  logic [31:0]   Addr;
  logic [31:0]   BUS;
  logic          INTin;
  logic [31:0]   INTnum;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string        name;
    logic [N-1:0] irq;
    logic         rd;
    logic [1:0]   wr;
    logic [31:0]  addr;
    logic [31:0]  bus;
    logic         exp_in;
    logic [31:0]  exp_num;
  } vec_t;

  vec_t vecs[$];

  int_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .irq      (irq),
    .Memread  (Memread),
    .Memwrite (Memwrite),
    .Addr     (Addr),
    .BUS      (BUS),
    .INTin    (INTin),
    .INTnum   (INTnum)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string n, logic [N-1:0] i, logic r, logic [1:0] w,
                              logic [31:0] a, logic [31:0] b, logic ei, logic [31:0] en);
    vec_t v;
    v.name = n; v.irq = i; v.rd = r; v.wr = w; v.addr = a; v.bus = b;
    v.exp_in = ei; v.exp_num = en;
    return v;
  endfunction

  function automatic void add(string n, logic [N-1:0] i, logic r, logic [1:0] w,
                              logic [31:0] a, logic [31:0] b, logic ei, logic [31:0] en);
    vecs.push_back(mk(n, i, r, w, a, b, ei, en));
  endfunction

  task automatic applyStimulus(input vec_t v);
    irq      = v.irq;
    Memread  = v.rd;
    Memwrite = v.wr;
    Addr     = v.addr;
    BUS      = v.bus;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic exp_in, input logic [31:0] exp_num);
    total++;
    if (INTin !== exp_in) begin
      bad++;
      $display("[TB] FAIL %s INTin got=%0b want=%0b", name, INTin, exp_in);
    end
    total++;
    if (INTnum !== exp_num) begin
      bad++;
      $display("[TB] FAIL %s INTnum got=%0d want=%0d", name, INTnum, exp_num);
    end
  endtask

  task automatic step(input string name, input logic [N-1:0] i, input logic r, input logic [1:0] w,
                      input logic [31:0] a, input logic [31:0] b, input logic ei, input logic [31:0] en);
    applyStimulus(mk(name, i, r, w, a, b, ei, en));
    checkOutput(name, ei, en);
  endtask

  initial begin
    int  lat;
    bit  seen;

    // test 1: single source, ack, EOI
    add("t1_en01",     8'h00, 0, 2'd0, 32'd0, 32'd0, 0, 0);
    vecs[$].wr = 2'd1; vecs[$].addr = A_EN; vecs[$].bus = 32'h01;
    add("t1_irq_k",    8'h01, 0, 2'd0, 32'd0, 32'd0, 0, 0);
    add("t1_k1",       8'h01, 0, 2'd0, 32'd0, 32'd0, 0, 0);
    add("t1_k2",       8'h01, 0, 2'd0, 32'd0, 32'd0, 0, 0);
    add("t1_k3",       8'h00, 0, 2'd0, 32'd0, 32'd0, 0, 0);
    add("t1_k4_req",   8'h00, 0, 2'd0, 32'd0, 32'd0, 1, 16);
    add("t1_hold",     8'h00, 0, 2'd0, 32'd0, 32'd0, 1, 16);
    add("t1_ack",      8'h00, 1, 2'd0, A_VEC, 32'd0, 0, 16);
    add("t1_eoi",      8'h00, 0, 2'd1, A_EOI, 32'd0, 0, 16);
    add("t1_idle",     8'h00, 0, 2'd0, 32'd0, 32'd0, 0, 16);
    // test 2: two simultaneous sources, priority order
    add("t2_enff",     8'h00, 0, 2'd1, A_EN,  32'hFF, 0, 16);
    add("t2_irq_k",    8'h24, 0, 2'd0, 32'd0, 32'd0, 0, 16);
    add("t2_k1",       8'h24, 0, 2'd0, 32'd0, 32'd0, 0, 16);
    add("t2_k2",       8'h24, 0, 2'd0, 32'd0, 32'd0, 0, 16);
    add("t2_k3",       8'h24, 0, 2'd0, 32'd0, 32'd0, 0, 16);
    add("t2_req18",    8'h24, 0, 2'd0, 32'd0, 32'd0, 1, 18);
    add("t2_ack",      8'h24, 1, 2'd0, A_VEC, 32'd0, 0, 18);
    add("t2_eoi",      8'h24, 0, 2'd1, A_EOI, 32'd0, 0, 18);
    add("t2_req21",    8'h24, 0, 2'd0, 32'd0, 32'd0, 1, 21);
    // test 3: higher priority arrives while REQ is frozen
    add("t3_irq0_k",   8'h25, 0, 2'd0, 32'd0, 32'd0, 1, 21);
    add("t3_k1",       8'h25, 0, 2'd0, 32'd0, 32'd0, 1, 21);
    add("t3_k2",       8'h25, 0, 2'd0, 32'd0, 32'd0, 1, 21);
    add("t3_k3",       8'h25, 0, 2'd0, 32'd0, 32'd0, 1, 21);
    add("t3_frozen",   8'h25, 0, 2'd0, 32'd0, 32'd0, 1, 21);
    add("t3_ack",      8'h25, 1, 2'd0, A_VEC, 32'd0, 0, 21);
    add("t3_eoi",      8'h25, 0, 2'd1, A_EOI, 32'd0, 0, 21);
    add("t3_req16",    8'h25, 0, 2'd0, 32'd0, 32'd0, 1, 16);
    add("t3_ack16",    8'h25, 1, 2'd0, A_VEC, 32'd0, 0, 16);
    add("t3_eoi16",    8'h25, 0, 2'd1, A_EOI, 32'd0, 0, 16);
    // test 4: pending but disabled, then enable, then software clear in REQ
    add("t4_en00",     8'h00, 0, 2'd1, A_EN,  32'h00, 0, 16);
    add("t4_irq3_k",   8'h08, 0, 2'd0, 32'd0, 32'd0, 0, 16);
    add("t4_k1",       8'h08, 0, 2'd0, 32'd0, 32'd0, 0, 16);
    add("t4_k2",       8'h08, 0, 2'd0, 32'd0, 32'd0, 0, 16);
    add("t4_k3",       8'h08, 0, 2'd0, 32'd0, 32'd0, 0, 16);
    add("t4_masked",   8'h08, 0, 2'd0, 32'd0, 32'd0, 0, 16);
    add("t4_en08",     8'h08, 0, 2'd1, A_EN,  32'h08, 0, 16);
    add("t4_req19",    8'h08, 0, 2'd0, 32'd0, 32'd0, 1, 19);
    add("t4_clr08",    8'h08, 0, 2'd1, A_CLR, 32'h08, 0, 19);
    add("t4_cleared",  8'h08, 0, 2'd0, 32'd0, 32'd0, 0, 19);
    // test 5: non-word writes and stray EOI/fetch are ignored
    add("t5_byte_en",  8'h08, 0, 2'd3, A_EN,  32'hFF, 0, 19);
    add("t5_irq1_k",   8'h0A, 0, 2'd0, 32'd0, 32'd0, 0, 19);
    add("t5_k1",       8'h0A, 0, 2'd0, 32'd0, 32'd0, 0, 19);
    add("t5_k2",       8'h0A, 0, 2'd0, 32'd0, 32'd0, 0, 19);
    add("t5_k3",       8'h0A, 0, 2'd0, 32'd0, 32'd0, 0, 19);
    add("t5_en_kept",  8'h0A, 0, 2'd0, 32'd0, 32'd0, 0, 19);
    add("t5_eoi_idle", 8'h0A, 0, 2'd1, A_EOI, 32'd0, 0, 19);
    add("t5_dma_en",   8'h0A, 0, 2'd2, A_EN,  32'hFF, 0, 19);
    add("t5_en02",     8'h0A, 0, 2'd1, A_EN,  32'h02, 0, 19);
    add("t5_req17",    8'h0A, 0, 2'd0, 32'd0, 32'd0, 1, 17);
    add("t5_eoi_req",  8'h0A, 0, 2'd1, A_EOI, 32'd0, 1, 17);
    add("t5_rd_other", 8'h0A, 1, 2'd0, 32'h0000_0400, 32'd0, 1, 17);
    add("t5_ack",      8'h0A, 1, 2'd0, A_VEC, 32'd0, 0, 17);
    add("t5_svc",      8'h0A, 0, 2'd0, 32'd0, 32'd0, 0, 17);
    add("t5_rd_svc",   8'h0A, 1, 2'd0, A_VEC, 32'd0, 0, 17);

    rst = 1'b1; irq = '0; Memread = 1'b0; Memwrite = 2'd0; Addr = '0; BUS = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 1'b0, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i].name, vecs[i].exp_in, vecs[i].exp_num);
    end

    // test 6: accumulate pending=0x06 while in SVC, then reset mid-service
    for (int i = 0; i < 3; i++) step("t6_low",  8'h00, 0, 2'd0, 32'd0, 32'd0, 0, 17);
    for (int i = 0; i < 4; i++) step("t6_pend", 8'h06, 0, 2'd0, 32'd0, 32'd0, 0, 17);
    rst = 1'b1;
    step("t6_rst", 8'h00, 0, 2'd0, 32'd0, 32'd0, 0, 0);
    rst = 1'b0;
    step("t6_enff", 8'h00, 0, 2'd1, A_EN, 32'hFF, 0, 0);
    for (int i = 0; i < 5; i++) step("t6_lost", 8'h00, 0, 2'd0, 32'd0, 32'd0, 0, 0);

    // state must be IDLE after reset: a fresh irq[4] is presented with normal latency
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 12) begin
      applyStimulus(mk("t6_irq4", 8'h10, 0, 2'd0, 32'd0, 32'd0, 0, 0));
      lat++;
      if (INTin === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen || lat != 5) begin
      bad++;
      $display("[TB] FAIL t6_irq4_latency got=%0d seen=%0b want=5", lat, seen);
    end
    checkOutput("t6_irq4_num", 1'b1, 32'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
